simple_gan_dense_engine: RTL and testbench
==========================================

# simple_gan_dense_engine

Sequencer/MAC engine that reads one fully-connected layer of the simple GAN out of the weight ROM and computes its neuron outputs. It is the consumer side of the ROM read interface. It drives weight/bias addresses, absorbs the ROM's 1-cycle synchronous read latency, and accumulates Q8.8 activations × Q1.7 weights plus a Q8.8 bias. It emits one Q8.8 result per output neuron. One instance serves each layer: G1 2→3, G2 3→9, D1 9→3, D2 3→1.

## Interface
- N_IN, 2: inputs per neuron (1..16)
- N_OUT, 3: output neurons (1..16)
- W_ADDR_W, 5: weight address width
- B_ADDR_W, 4: bias address width
- A_ADDR_W, 4: activation address width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- relu_en  in  1  sampled at accepted start; 1 = clamp negative results to 0
- w_addr  out  W_ADDR_W  weight ROM address, row-major o*N_IN+i
- w_data  in  8  signed Q1.7, valid 1 cycle after w_addr
- b_addr  out  B_ADDR_W  bias ROM address = o
- b_data  in  16  signed Q8.8, valid 1 cycle after b_addr
- a_addr  out  A_ADDR_W  activation buffer address = i
- a_data  in  16  signed Q8.8, valid 1 cycle after a_addr
- busy  out  1  high while a layer is in progress
- out_valid  out  1  one-cycle strobe per neuron
- out_idx  out  B_ADDR_W  neuron index o of out_data
- out_data  out  16  signed Q8.8 result
- done  out  1  one-cycle pulse, coincident with last out_valid

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: accepted start → FETCH with o=0, i=0; relu_en latched; busy=1 from next cycle.
- FETCH: w_addr, a_addr and b_addr are combinational from counters o and i. i increments each cycle. After i=N_IN-1 → DRAIN.
- A pipeline valid flag, delayed 1 cycle from FETCH, qualifies accumulation.
- First product of a neuron: acc ← (b_data <<< 7) + a_data*w_data. Subsequent products: acc ← acc + a_data*w_data.
- DRAIN: the last product is added. The final sum is rounded, optionally ReLU'd, saturated, and registered into out_data/out_idx. out_valid is set for the next cycle.
- After DRAIN: if o<N_OUT-1, o++, i=0 → FETCH. The next neuron's fetch overlaps the out_valid cycle. Otherwise → IDLE, with done asserted alongside out_valid.
- Arithmetic:
  - Product is 24-bit signed Q9.15.
  - acc is 32-bit signed and never overflows for N_IN ≤ 16.
  - Result = (acc + 64) >>> 7 (round half up), then ReLU if latched, then saturate to [-32768, 32767].
- start while busy is ignored, with no effect on the current layer.
- Reset, including mid-layer: state IDLE, counters 0, acc 0, pipeline flag 0. All outputs go to 0: w_addr, b_addr, a_addr, busy, out_valid, out_idx, out_data, done. No partial result is emitted.

## Timing
- start is sampled high at edge of cycle 0. FETCH occupies cycles 1..N_IN, DRAIN occupies cycle N_IN+1.
- Neuron o: out_valid high in cycle (o+1)(N_IN+1)+1. Per-neuron throughput is N_IN+1 cycles.
- done coincides with the out_valid of neuron N_OUT-1. busy is high from cycle 1 through that cycle, then low.
- A new start is accepted in the first cycle busy is low.
- out_data/out_idx hold their value until the next out_valid.
- ROM and activation buffer must present data exactly 1 cycle after the address; no stall input exists.

## Test plan
- G1 layer (N_IN=2, N_OUT=3) against the real ROM. Activations [256, 128] (1.0, 0.5). Weights {7,11; 23,4; -29,-17}, biases 0, relu_en=0 → out_data 25, 50, -75 (0xFFB5) at cycles 4, 7, 10, with out_idx 0, 1, 2; done at cycle 10; busy low at cycle 11.
- Same stimulus with relu_en=1 → outputs 25, 50, 0.
- Rounding, with a stub ROM, N_IN=1, bias 0, activation 1:
  - weight 64 → out_data 1
  - weight 63 → out_data 0
  - activation -1 with weight 64 → 0
- Saturation, N_IN=9, all activations 32767, all weights 127, bias 0 → out_data 32767. Same with weights -128 → -32768.
- Bias path: N_IN=1, activation 0, bias 0x0180 → out_data 0x0180 (1.5). Negative bias 0xFF00 with relu_en=1 → 0.
- Control:
  - start pulsed during busy → ignored; output sequence and timing unchanged.
  - rst_n low at cycle 5 of the G1 run → all outputs 0 immediately; no out_valid or done. A fresh start after release reproduces 25, 50, -75.

Source files
------------

// File: rtl/simple_gan_dense_engine.sv
// Dense-layer sequencer/MAC for the simple GAN. It walks o/i over the weight,
// bias and activation stores, and absorbs their 1-cycle read latency with a
// delayed valid flag. It accumulates Q8.8 x Q1.7 products on top of a Q8.8
// bias, and emits one rounded, optionally ReLU'd, saturated Q8.8 result per
// output neuron.
module simple_gan_dense_engine #(
  parameter int N_IN     = 2,
  parameter int N_OUT    = 3,
  parameter int W_ADDR_W = 5,
  parameter int B_ADDR_W = 4,
  parameter int A_ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                relu_en,
  output logic [W_ADDR_W-1:0] w_addr,
  input  logic [7:0]          w_data,
  output logic [B_ADDR_W-1:0] b_addr,
  input  logic [15:0]         b_data,
  output logic [A_ADDR_W-1:0] a_addr,
  input  logic [15:0]         a_data,
  output logic                busy,
  output logic                out_valid,
  output logic [B_ADDR_W-1:0] out_idx,
  output logic [15:0]         out_data,
  output logic                done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [A_ADDR_W-1:0] I_LAST = A_ADDR_W'(N_IN - 1);
  localparam logic [B_ADDR_W-1:0] O_LAST = B_ADDR_W'(N_OUT - 1);

  logic [1:0]          state_q, state_d;
  logic [B_ADDR_W-1:0] o_q, o_d;
  logic [A_ADDR_W-1:0] i_q, i_d;
  logic                relu_q, relu_d;
  logic                busy_q, busy_d;
  // vld/first/last trail the fetch by one cycle, lining up with ROM data
  logic                vld_q, vld_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic signed [31:0]  acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [B_ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                done_q, done_d;

  logic                accept;
  logic signed [23:0]  prod;
  logic signed [31:0]  prod_ext, bias_ext, sum, rnd, rl;
  logic [15:0]         sat;

  // Addresses come straight from the counters; the stores register them
  assign w_addr = W_ADDR_W'(o_q) * W_ADDR_W'(N_IN) + W_ADDR_W'(i_q);
  assign b_addr = o_q;
  assign a_addr = i_q;

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

  // MAC datapath: Q9.15 product, bias lifted to the same scale, round/clamp
  always_comb begin
    prod     = $signed({{8{a_data[15]}}, a_data}) * $signed({{16{w_data[7]}}, w_data});
    prod_ext = {{8{prod[23]}}, prod};
    bias_ext = {{9{b_data[15]}}, b_data, 7'd0};
    sum      = (first_q ? bias_ext : acc_q) + prod_ext;
    rnd      = (sum + 32'sd64) >>> 7;
    rl       = (relu_q && rnd < 0) ? 32'sd0 : rnd;
    if (rl > 32'sd32767)       sat = 16'h7fff;
    else if (rl < -32'sd32768) sat = 16'h8000;
    else                       sat = rl[15:0];
  end

  // Sequencer: IDLE -> FETCH (N_IN cycles) -> DRAIN -> next neuron or IDLE
  always_comb begin
    state_d     = state_q;
    o_d         = o_q;
    i_d         = i_q;
    relu_d      = relu_q;
    busy_d      = busy_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    // busy stays up in the done cycle, so a start there is still ignored
    accept      = start && (state_q == S_IDLE) && !busy_q;
    vld_d       = (state_q == S_FETCH);
    first_d     = (state_q == S_FETCH) && (i_q == '0);
    last_d      = (state_q == S_FETCH) && (i_q == I_LAST);

    if (done_q) busy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FETCH;
          o_d     = '0;
          i_d     = '0;
          relu_d  = relu_en;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (i_q == I_LAST) begin
          state_d = S_DRAIN;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (o_q == O_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
          o_d     = o_q + 1'b1;
          i_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Product of the last input closes the neuron; o_q still names it here
    if (vld_q) begin
      acc_d = sum;
      if (last_q) begin
        out_valid_d = 1'b1;
        out_idx_d   = o_q;
        out_data_d  = sat;
        done_d      = (o_q == O_LAST);
      end
    end
  end

  // State registers; reset drops any partial neuron
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      o_q         <= '0;
      i_q         <= '0;
      relu_q      <= 1'b0;
      busy_q      <= 1'b0;
      vld_q       <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      i_q         <= i_d;
      relu_q      <= relu_d;
      busy_q      <= busy_d;
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_simple_gan_dense_engine.sv
// Directed bench: a G1-shaped instance (2->3) with the real layer weights, and
// single-neuron instances (N_IN=1, N_IN=9) with stub stores for rounding,
// saturation and bias corner cases.
module tb_simple_gan_dense_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic relu_en = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- G1 instance: N_IN=2, N_OUT=3
  logic [4:0] g1_wa; logic [3:0] g1_ba, g1_aa, g1_idx;
  logic [7:0] g1_wd; logic [15:0] g1_bd, g1_ad, g1_dat;
  logic g1_busy, g1_vld, g1_done;
  logic [7:0]  g1_wm [0:31];
  logic [15:0] g1_bm [0:15];
  logic [15:0] g1_am [0:15];
  always @(posedge clk) begin
    g1_wd <= g1_wm[g1_wa]; g1_bd <= g1_bm[g1_ba]; g1_ad <= g1_am[g1_aa];
  end
  simple_gan_dense_engine #(.N_IN(2), .N_OUT(3), .W_ADDR_W(5), .B_ADDR_W(4), .A_ADDR_W(4)) u_g1 (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
    .w_addr(g1_wa), .w_data(g1_wd), .b_addr(g1_ba), .b_data(g1_bd),
    .a_addr(g1_aa), .a_data(g1_ad), .busy(g1_busy), .out_valid(g1_vld),
    .out_idx(g1_idx), .out_data(g1_dat), .done(g1_done));

  // ---------------- single-input instance
  logic [4:0] n1_wa; logic [3:0] n1_ba, n1_aa, n1_idx;
  logic [7:0] n1_wd; logic [15:0] n1_bd, n1_ad, n1_dat;
  logic n1_busy, n1_vld, n1_done;
  logic [7:0]  n1_wm [0:31];
  logic [15:0] n1_bm [0:15];
  logic [15:0] n1_am [0:15];
  always @(posedge clk) begin
    n1_wd <= n1_wm[n1_wa]; n1_bd <= n1_bm[n1_ba]; n1_ad <= n1_am[n1_aa];
  end
  simple_gan_dense_engine #(.N_IN(1), .N_OUT(1), .W_ADDR_W(5), .B_ADDR_W(4), .A_ADDR_W(4)) u_n1 (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
    .w_addr(n1_wa), .w_data(n1_wd), .b_addr(n1_ba), .b_data(n1_bd),
    .a_addr(n1_aa), .a_data(n1_ad), .busy(n1_busy), .out_valid(n1_vld),
    .out_idx(n1_idx), .out_data(n1_dat), .done(n1_done));

  // ---------------- nine-input instance
  logic [4:0] n9_wa; logic [3:0] n9_ba, n9_aa, n9_idx;
  logic [7:0] n9_wd; logic [15:0] n9_bd, n9_ad, n9_dat;
  logic n9_busy, n9_vld, n9_done;
  logic [7:0]  n9_wm [0:31];
  logic [15:0] n9_bm [0:15];
  logic [15:0] n9_am [0:15];
  always @(posedge clk) begin
    n9_wd <= n9_wm[n9_wa]; n9_bd <= n9_bm[n9_ba]; n9_ad <= n9_am[n9_aa];
  end
  simple_gan_dense_engine #(.N_IN(9), .N_OUT(1), .W_ADDR_W(5), .B_ADDR_W(4), .A_ADDR_W(4)) u_n9 (
    .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
    .w_addr(n9_wa), .w_data(n9_wd), .b_addr(n9_ba), .b_data(n9_bd),
    .a_addr(n9_aa), .a_data(n9_ad), .busy(n9_busy), .out_valid(n9_vld),
    .out_idx(n9_idx), .out_data(n9_dat), .done(n9_done));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full G1 layer, checked cycle by cycle (cycle 0 = start sampling edge).
  // poke pulses start mid-layer, which must change nothing.
  task automatic run_g1(input logic relu, input logic [15:0] e2, input logic poke);
    relu_en = relu; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      if (poke) start = (k == 5);
      chk("g1_valid", 32'(g1_vld), 32'(k == 4 || k == 7 || k == 10));
      chk("g1_done",  32'(g1_done), 32'(k == 10));
      chk("g1_busy",  32'(g1_busy), 32'(k <= 10));
      if (k == 1) chk("g1_waddr_c1", 32'(g1_wa), 32'd0);
      if (k == 5) begin
        chk("g1_waddr_c5", 32'(g1_wa), 32'd3);
        chk("g1_baddr_c5", 32'(g1_ba), 32'd1);
        chk("g1_aaddr_c5", 32'(g1_aa), 32'd1);
      end
      if (k == 4)  begin chk("g1_o0", 32'(g1_dat), 32'd25); chk("g1_idx0", 32'(g1_idx), 32'd0); end
      if (k == 6)  chk("g1_hold0", 32'(g1_dat), 32'd25);
      if (k == 7)  begin chk("g1_o1", 32'(g1_dat), 32'd50); chk("g1_idx1", 32'(g1_idx), 32'd1); end
      if (k == 10) begin chk("g1_o2", 32'(g1_dat), 32'(e2)); chk("g1_idx2", 32'(g1_idx), 32'd2); end
      if (k == 12) chk("g1_hold2", 32'(g1_dat), 32'(e2));
    end
    start = 1'b0;
  endtask

  // One single-neuron layer on u_n1 (sel=0) or u_n9 (sel=1)
  task automatic run_one(input int sel, input logic relu, input logic [15:0] exp, input string tag);
    bit seen = 0;
    int ecyc = (sel == 0) ? 3 : 11;
    relu_en = relu; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      if (k > 1) tick();
      if ((sel == 0) ? n1_vld : n9_vld) begin
        seen = 1;
        chk({tag, "_cycle"}, 32'(k), 32'(ecyc));
        chk({tag, "_data"}, 32'((sel == 0) ? n1_dat : n9_dat), 32'(exp));
        chk({tag, "_done"}, 32'((sel == 0) ? n1_done : n9_done), 32'd1);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (3) tick();
  endtask

  task automatic set_n1(input logic [15:0] a, input logic [7:0] w, input logic [15:0] b);
    n1_am[0] = a; n1_wm[0] = w; n1_bm[0] = b;
  endtask

  initial begin
    for (int j = 0; j < 32; j++) begin g1_wm[j] = 8'd0; n1_wm[j] = 8'd0; n9_wm[j] = 8'd0; end
    for (int j = 0; j < 16; j++) begin
      g1_bm[j] = 16'd0; g1_am[j] = 16'd0; n1_bm[j] = 16'd0;
      n1_am[j] = 16'd0; n9_bm[j] = 16'd0; n9_am[j] = 16'd0;
    end
    g1_wm[0] = 8'sd7;   g1_wm[1] = 8'sd11;
    g1_wm[2] = 8'sd23;  g1_wm[3] = 8'sd4;
    g1_wm[4] = -8'sd29; g1_wm[5] = -8'sd17;
    g1_am[0] = 16'd256; g1_am[1] = 16'd128;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(g1_busy), 32'd0);
    chk("rst_valid", 32'(g1_vld), 32'd0);
    chk("rst_data", 32'(g1_dat), 32'd0);
    chk("rst_waddr", 32'(g1_wa), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    run_g1(1'b0, 16'hffb5, 1'b0);
    run_g1(1'b1, 16'h0000, 1'b0);
    run_g1(1'b0, 16'hffb5, 1'b1);

    // reset mid-layer at cycle 5
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0; #1;
    chk("mrst_busy", 32'(g1_busy), 32'd0);
    chk("mrst_valid", 32'(g1_vld), 32'd0);
    chk("mrst_done", 32'(g1_done), 32'd0);
    chk("mrst_data", 32'(g1_dat), 32'd0);
    chk("mrst_idx", 32'(g1_idx), 32'd0);
    chk("mrst_addrs", 32'({g1_wa, g1_ba, g1_aa}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_quiet", 32'({g1_vld, g1_done, g1_busy}), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    run_g1(1'b0, 16'hffb5, 1'b0);

    // rounding
    set_n1(16'd1, 8'sd64, 16'd0);       run_one(0, 1'b0, 16'd1, "rnd_half");
    set_n1(16'd1, 8'sd63, 16'd0);       run_one(0, 1'b0, 16'd0, "rnd_below");
    set_n1(16'hffff, 8'sd64, 16'd0);    run_one(0, 1'b0, 16'd0, "rnd_neg_half");
    // bias path
    set_n1(16'd0, 8'sd5, 16'h0180);     run_one(0, 1'b0, 16'h0180, "bias_pos");
    set_n1(16'd0, 8'sd5, 16'hff00);     run_one(0, 1'b0, 16'hff00, "bias_neg");
    set_n1(16'd0, 8'sd5, 16'hff00);     run_one(0, 1'b1, 16'h0000, "bias_relu");

    // saturation
    for (int j = 0; j < 9; j++) begin n9_am[j] = 16'h7fff; n9_wm[j] = 8'sd127; end
    run_one(1, 1'b0, 16'h7fff, "sat_pos");
    for (int j = 0; j < 9; j++) n9_wm[j] = 8'h80;
    run_one(1, 1'b0, 16'h8000, "sat_neg");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
